// File: rtl/custom_ahb_regbank_slave.sv
// AHB-Lite register bank slave: 14 R/W words, an access counter and an ID word,
// with a configurable number of data-phase wait states and two-cycle ERROR responses.
module custom_ahb_regbank_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4D36_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [3:0]  HPROTS,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic [31:0] HWDATAS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic [31:0] HRDATAS
);
  localparam logic [2:0] LP_WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t      r_state, w_nxt;
  logic        r_dp, r_write;
  logic [3:0]  r_idx, r_be;
  logic [2:0]  r_wcnt;
  logic [31:0] r_acc_cnt;
  logic [31:0] r_mem [14];

  logic        w_acc, w_err, w_rdy, w_final;
  logic [3:0]  w_be;
  logic [31:0] w_rword;
  logic        w_unused;

  assign w_unused = ^{HPROTS, HBURSTS, HMASTERS, HMASTLOCKS, HADDRS[31:12]};
  assign w_acc    = HSELS & HTRANSS[1] & HREADYS;

  always_comb begin
    w_err = (HSIZES > 3'b010)
          | ((HSIZES == 3'b001) & HADDRS[0])
          | ((HSIZES == 3'b010) & (|HADDRS[1:0]))
          | (|HADDRS[11:6])
          | (HWRITES & (HADDRS[5:3] == 3'b111));
    case (HSIZES[1:0])
      2'b00:   w_be = 4'b0001 << HADDRS[1:0];
      2'b01:   w_be = HADDRS[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // IDLE and ERR2 are both "ready" states, so a new address phase is decoded from either.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (!w_acc)           w_nxt = S_IDLE;
        else if (w_err)       w_nxt = S_ERR1;
        else if (LP_WS != 0)  w_nxt = S_WAIT;
        else                  w_nxt = S_IDLE;
      end
      S_WAIT:  if (r_wcnt <= 3'd1) w_nxt = S_IDLE;
      S_ERR1:  w_nxt = S_ERR2;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdy   = 1'b1;
    HRESPS  = 1'b0;
    w_final = 1'b0;
    HRDATAS = '0;
    case (r_state)
      S_WAIT:  w_rdy = 1'b0;
      S_ERR1:  begin w_rdy = 1'b0; HRESPS = 1'b1; end
      S_ERR2:  HRESPS = 1'b1;
      default: w_final = r_dp;
    endcase
    if (w_final && !r_write) HRDATAS = w_rword;
  end
  assign HREADYOUTS = w_rdy;

  // Word 14 returns the count before this access's own increment.
  always_comb begin
    w_rword = '0;
    if (r_idx == 4'd14)      w_rword = r_acc_cnt;
    else if (r_idx == 4'd15) w_rword = ID_VALUE;
    else
      for (int i = 0; i < 14; i++)
        if (r_idx == 4'(i)) w_rword = r_mem[i];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp      <= 1'b0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_be      <= '0;
      r_wcnt    <= '0;
      r_acc_cnt <= '0;
      for (int i = 0; i < 14; i++) r_mem[i] <= '0;
    end else begin
      if (w_rdy) begin
        r_dp <= w_acc & ~w_err;
        if (w_acc) begin
          r_idx   <= HADDRS[5:2];
          r_write <= HWRITES;
          r_be    <= w_be;
        end
      end
      if (w_rdy && w_acc)         r_wcnt <= LP_WS;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt - 3'd1;
      if (w_final) begin
        r_acc_cnt <= r_acc_cnt + 32'd1;
        if (r_write)
          for (int i = 0; i < 14; i++)
            for (int b = 0; b < 4; b++)
              if (r_idx == 4'(i) && r_be[b]) r_mem[i][8*b +: 8] <= HWDATAS[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_custom_ahb_regbank_slave.sv
// Bench for custom_ahb_regbank_slave: two instances (WAIT_STATES 1 and 0), a transfer-level
// model checked every cycle, directed literal expectations, then randomized traffic.
module tb_custom_ahb_regbank_slave;
  localparam logic [31:0] ID = 32'h4D36_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        sel  [2];
  logic [31:0] addr [2];
  logic [1:0]  trans[2];
  logic        wr   [2];
  logic [2:0]  size [2];
  logic [31:0] wdata[2];
  logic        rdy  [2];
  logic        rsp  [2];
  logic [31:0] rdata[2];

  logic        lit_v[2], lit_rdy[2], lit_rsp[2];
  logic [31:0] lit_dat[2];
  logic        do_force[2];

  int unsigned vec = 0, nerr = 0;

  custom_ahb_regbank_slave #(.WAIT_STATES(1), .ID_VALUE(ID)) u_dut0 (
    .HCLK(clk), .HRESETn(rstn[0]), .HSELS(sel[0]), .HADDRS(addr[0]), .HTRANSS(trans[0]),
    .HWRITES(wr[0]), .HSIZES(size[0]), .HPROTS(4'h3), .HBURSTS(3'h0), .HMASTERS(4'h1),
    .HMASTLOCKS(1'b0), .HREADYS(rdy[0]), .HWDATAS(wdata[0]),
    .HREADYOUTS(rdy[0]), .HRESPS(rsp[0]), .HRDATAS(rdata[0]));

  custom_ahb_regbank_slave #(.WAIT_STATES(0), .ID_VALUE(ID)) u_dut1 (
    .HCLK(clk), .HRESETn(rstn[1]), .HSELS(sel[1]), .HADDRS(addr[1]), .HTRANSS(trans[1]),
    .HWRITES(wr[1]), .HSIZES(size[1]), .HPROTS(4'h3), .HBURSTS(3'h0), .HMASTERS(4'h1),
    .HMASTLOCKS(1'b0), .HREADYS(rdy[1]), .HWDATAS(wdata[1]),
    .HREADYOUTS(rdy[1]), .HRESPS(rsp[1]), .HRDATAS(rdata[1]));

  // Model: the data phase in progress (0 none, 1 okay, 2 error-first, 3 error-last).
  logic [31:0] m_mem [2][16];
  logic [31:0] m_cnt [2];
  int          m_kind[2], m_rem[2];
  logic [3:0]  m_idx [2], m_be[2];
  logic        m_wr  [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic        e_rdy, e_rsp, err;
    logic [31:0] e_dat, a;
    for (int k = 0; k < 2; k++) begin
      if (!rstn[k]) begin
        m_kind[k] = 0;
        m_cnt[k]  = '0;
        for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      end
      if (do_force[k]) m_cnt[k] = 32'hFFFF_FFFF;
      e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
      if (m_kind[k] == 1 && m_rem[k] > 0) e_rdy = 1'b0;
      else if (m_kind[k] == 1 && !m_wr[k])
        e_dat = (m_idx[k] == 4'd14) ? m_cnt[k] : (m_idx[k] == 4'd15) ? ID : m_mem[k][m_idx[k]];
      else if (m_kind[k] == 2) begin e_rdy = 1'b0; e_rsp = 1'b1; end
      else if (m_kind[k] == 3) e_rsp = 1'b1;
      chk("hreadyout", k, 32'(rdy[k]), 32'(e_rdy));
      chk("hresp",     k, 32'(rsp[k]), 32'(e_rsp));
      chk("hrdata",    k, rdata[k], e_dat);
      if (lit_v[k]) begin
        chk("lit_hreadyout", k, 32'(rdy[k]), 32'(lit_rdy[k]));
        chk("lit_hresp",     k, 32'(rsp[k]), 32'(lit_rsp[k]));
        chk("lit_hrdata",    k, rdata[k], lit_dat[k]);
      end
      if (rstn[k]) begin
        if (m_kind[k] == 1 && m_rem[k] > 0) m_rem[k]--;
        else if (m_kind[k] == 2) m_kind[k] = 3;
        else begin
          if (m_kind[k] == 1) begin
            if (m_wr[k])
              for (int b = 0; b < 4; b++)
                if (m_be[k][b]) m_mem[k][m_idx[k]][8*b +: 8] = wdata[k][8*b +: 8];
            m_cnt[k] = m_cnt[k] + 1;
          end
          if (sel[k] && trans[k][1]) begin
            a   = addr[k];
            err = (size[k] > 2) || (size[k] == 1 && a[0]) || (size[k] == 2 && a[1:0] != 0)
                  || (a[11:6] != 0) || (wr[k] && a[5:2] >= 14);
            m_kind[k] = err ? 2 : 1;
            m_rem[k]  = (k == 0) ? 1 : 0;
            m_idx[k]  = a[5:2];
            m_wr[k]   = wr[k];
            m_be[k]   = (size[k] == 0) ? 4'(1 << a[1:0]) : (size[k] == 1) ? (a[1] ? 4'hC : 4'h3) : 4'hF;
          end else m_kind[k] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) lit_v[k] = 1'b0;
  endtask

  task automatic ap(input int k, input logic w, input logic [2:0] s, input logic [31:0] a);
    sel[k] = 1'b1; trans[k] = 2'b10; wr[k] = w; size[k] = s; addr[k] = a;
  endtask

  task automatic idle(input int k);
    sel[k] = 1'b0; trans[k] = 2'b00;
  endtask

  task automatic ex(input int k, input logic r, input logic p, input logic [31:0] d);
    lit_v[k] = 1'b1; lit_rdy[k] = r; lit_rsp[k] = p; lit_dat[k] = d;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; idle(k); wr[k] = 1'b0; size[k] = '0; addr[k] = '0; wdata[k] = '0;
      lit_v[k] = 1'b0; lit_rdy[k] = 1'b0; lit_rsp[k] = 1'b0; lit_dat[k] = '0; do_force[k] = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin ex(0, 1, 0, 0); ex(1, 1, 0, 0); step(); end
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // dut0 (1 wait): write word 0, read it back pipelined
    ap(0, 1, 2, 32'h0); step();
    ex(0, 0, 0, 0); wdata[0] = 32'hA5A5_5A5A; idle(0); step();
    ex(0, 1, 0, 0); ap(0, 0, 2, 32'h0); step();
    ex(0, 0, 0, 0); idle(0); step();
    ex(0, 1, 0, 32'hA5A5_5A5A); step();
    // errors: misaligned halfword, write to word 14, then out-of-range read taken in ERR2
    ap(0, 0, 1, 32'h1); step();
    ex(0, 0, 1, 0); idle(0); step();
    ex(0, 1, 1, 0); ap(0, 1, 2, 32'h38); step();
    ex(0, 0, 1, 0); wdata[0] = 32'hDEAD_BEEF; ap(0, 0, 2, 32'h40); step();
    ex(0, 1, 1, 0); step();
    ex(0, 0, 1, 0); idle(0); step();
    ex(0, 1, 1, 0); ap(0, 0, 2, 32'h0); step();
    ex(0, 0, 0, 0); idle(0); step();
    ex(0, 1, 0, 32'hA5A5_5A5A); ap(0, 0, 2, 32'h38); step();
    ex(0, 0, 0, 0); idle(0); step();
    ex(0, 1, 0, 32'd3); step();

    // dut1 (0 wait): ID, counter x3, byte merge, back-to-back
    ap(1, 0, 2, 32'h3C); step();
    ex(1, 1, 0, ID); ap(1, 0, 2, 32'h38); step();
    ex(1, 1, 0, 32'd1); step();
    ex(1, 1, 0, 32'd2); step();
    ex(1, 1, 0, 32'd3); idle(1); step();
    ap(1, 1, 2, 32'h4); step();
    ex(1, 1, 0, 0); wdata[1] = 32'h1122_3344; ap(1, 1, 0, 32'h6); step();
    ex(1, 1, 0, 0); wdata[1] = 32'hFF3C_FFFF; ap(1, 0, 2, 32'h4); step();
    ex(1, 1, 0, 32'h113C_3344); idle(1); step();
    // counter wrap
    force u_dut1.r_acc_cnt = 32'hFFFF_FFFF;
    do_force[1] = 1'b1; ap(1, 0, 2, 32'h0);
    @(negedge clk); #1;
    release u_dut1.r_acc_cnt;
    do_force[1] = 1'b0;
    step();
    ex(1, 1, 0, 0); ap(1, 0, 2, 32'h38); step();
    ex(1, 1, 0, 0); idle(1); step();

    // dut0: reset during the wait cycle of a write aborts it
    ap(0, 1, 2, 32'h8); step();
    wdata[0] = 32'h1234_5678; idle(0); rstn[0] = 1'b0; ex(0, 1, 0, 0); step();
    ex(0, 1, 0, 0); step();
    rstn[0] = 1'b1; ex(0, 1, 0, 0); ap(0, 0, 2, 32'h8); step();
    ex(0, 0, 0, 0); idle(0); step();
    ex(0, 1, 0, 0); ap(0, 0, 2, 32'h38); step();
    ex(0, 0, 0, 0); idle(0); step();
    ex(0, 1, 0, 32'd1); step();

    // randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rstn[k]) rstn[k] = 1'b1;
        else if ($urandom_range(0, 399) == 0) rstn[k] = 1'b0;
        r = $urandom_range(0, 15);
        size[k] = (r < 14) ? 3'(r % 3) : 3'($urandom_range(3, 7));
        a = $urandom & 32'h3F;
        if ($urandom_range(0, 3) != 0) begin
          if (size[k] == 1) a[0] = 1'b0;
          if (size[k] == 2) a[1:0] = 2'b00;
        end
        if ($urandom_range(0, 15) == 0) a = a | (32'h40 << $urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
        addr[k]  = a;
        sel[k]   = ($urandom_range(0, 3) != 0);
        trans[k] = 2'($urandom_range(0, 3));
        wr[k]    = $urandom_range(0, 1) == 1;
        wdata[k] = $urandom;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin idle(k); rstn[k] = 1'b1; end
    step(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, nerr);
    $finish;
  end
endmodule

// File: doc/custom_ahb_regbank_slave.md
CUSTOM_AHB_REGBANK_SLAVE -- requirements
Module: custom_ahb_regbank_slave

Interface
REQ-001 Parameter WAIT_STATES, default 1, meaning: data-phase wait cycles for OKAY transfers, legal range 0..7.
REQ-002 Parameter ID_VALUE, default 32'h4D36_0001, meaning: read-only contents of word 15.
REQ-003 HCLK  input  1  AHB system clock. All state changes on the rising edge.
REQ-004 HRESETn  input  1  AHB system reset, asynchronous assert, active-low.
REQ-005 HSELS  input  1  slave select.
REQ-006 HADDRS  input  32  address.
REQ-007 HTRANSS  input  2  transfer type.
REQ-008 HWRITES  input  1  transfer direction.
REQ-009 HSIZES  input  3  transfer size.
REQ-010 HPROTS, HBURSTS, HMASTERS, HMASTLOCKS  inputs  4, 3, 4, 1  accepted and ignored.
REQ-011 HREADYS  input  1  HREADYMUX from the bus matrix output stage.
REQ-012 HWDATAS  input  32  write data.
REQ-013 HREADYOUTS  output  1  transfer done.
REQ-014 HRESPS  output  1  0 = OKAY, 1 = ERROR.
REQ-015 HRDATAS  output  32  read data.

Function
REQ-016 Storage: 16 x 32-bit words, index HADDRS[5:2]; words 0..13 read/write; word 14 = read-only access counter; word 15 = read-only ID_VALUE.
REQ-017 Accept condition at a rising edge: HSELS & HTRANSS[1] & HREADYS. Capture address, size, and direction at that edge.
REQ-018 IDLE/BUSY transfers, and cycles with HSELS low: no capture; the next data phase is zero-wait OKAY.
REQ-019 Error condition at accept, evaluated in this order:
  - HSIZES > 3'b010
  - misaligned: size 1 with HADDRS[0] = 1, or size 2 with HADDRS[1:0] != 0
  - HADDRS[11:6] != 0
  - write to word 14 or word 15
REQ-020 FSM states and transitions:
  - IDLE → WAIT when an OKAY access is accepted and WAIT_STATES > 0; IDLE → IDLE for a zero-wait OKAY access.
  - IDLE → ERR1 when an error access is accepted.
  - WAIT → IDLE when the down-counter reaches 0.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → IDLE, or ERR2 → WAIT/ERR1 when a new transfer is accepted in that same cycle.
REQ-021 Wait counter: 3-bit, loaded with WAIT_STATES on accept, decremented each WAIT cycle.
REQ-022 OKAY timing, with accept at edge T:
  - HREADYOUTS = 0 for cycles T+1..T+WAIT_STATES.
  - HREADYOUTS = 1 in cycle T+WAIT_STATES+1 (the final data-phase cycle).
  - HRESPS = 0 throughout.
REQ-023 ERROR timing: ERR1 drives HREADYOUTS = 0, HRESPS = 1; ERR2 drives HREADYOUTS = 1, HRESPS = 1. WAIT_STATES is not inserted for errors, and errored writes leave storage unchanged.
REQ-024 Read data:
  - HRDATAS = full 32-bit word in the final OKAY data-phase cycle only, regardless of HSIZES.
  - HRDATAS = 0 in every other cycle.
REQ-025 Write commit: at the edge ending the final OKAY data-phase cycle, using HWDATAS of that cycle. Little-endian byte lanes:
  - size 0: lane HADDRS[1:0]
  - size 1: lanes {HADDRS[1],0} and {HADDRS[1],1}
  - size 2: all lanes
  - unwritten lanes keep their value.
REQ-026 Access counter (word 14):
  - Increments by 1 at the end of each completed OKAY NONSEQ/SEQ data phase, read or write.
  - Wraps 32'hFFFF_FFFF → 0.
  - A read of word 14 returns the pre-increment value.
REQ-027 Pipelining: a new address phase is accepted in the final cycle of the previous data phase (HREADYS = 1), including ERR2. Back-to-back zero-wait accesses shall sustain one transfer per cycle. A read following a write to the same word returns the new data.
REQ-028 Accept condition is gated by HREADYS: while HREADYOUTS = 0, new address-phase inputs are ignored.

Reset
REQ-029 While HRESETn = 0: FSM = IDLE, counter = 0, HREADYOUTS = 1, HRESPS = 0, HRDATAS = 0, words 0..14 = 0, word 15 = ID_VALUE.
REQ-030 Reset asserted mid-transfer aborts it: no write commits, and the access counter does not increment.

Verification
REQ-031 WAIT_STATES = 1; write word 0 = 32'hA5A5_5A5A, size 2, then read word 0 → one low HREADYOUTS cycle per transfer; read returns 32'hA5A5_5A5A, HRESPS = 0.
REQ-032 WAIT_STATES = 0; byte write 8'h3C to address 0x06 over word 1 = 32'h1122_3344, then read → 32'h113C_3344, zero-wait, back-to-back.
REQ-033 Halfword access to 0x01; write to 0x38; read of 0x40 → each gives ERR1 (HREADYOUTS = 0, HRESPS = 1) then ERR2 (HREADYOUTS = 1, HRESPS = 1); storage unchanged; counter not incremented.
REQ-034 Read word 15 after reset → 32'h4D36_0001. Read word 14 three times → 1, 2, 3 (the word 15 read counted). Force counter to 32'hFFFF_FFFF, complete one access → next word 14 read returns 0.
REQ-035 Assert HRESETn low during a WAIT cycle of a write → no commit; after release, HREADYOUTS = 1 and the word reads 0.
